spi_txn_scheduler: RTL

- Upstream companion to spi_master: queues SPI transactions from a host (CPU/bus bridge) and launches them one at a time on spi_master's start/busy handshake.
- Collects each transaction's received word into a response queue.
- Host issues back-to-back commands without polling busy; master sees exactly one start per transaction plus a guaranteed chip-select gap.

---
 rtl/spi_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/spi_txn_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared encodings for the SPI transaction scheduler: field widths, length codes,
// the per-length receive mask and the scheduler FSM states.
package spi_pkg;

  localparam int DATA_W = 32;
  localparam int CHIP_W = 3;
  localparam int LEN_W  = 2;

  localparam logic [LEN_W-1:0] LEN_8  = 2'd0;
  localparam logic [LEN_W-1:0] LEN_16 = 2'd1;
  localparam logic [LEN_W-1:0] LEN_24 = 2'd2;
  localparam logic [LEN_W-1:0] LEN_32 = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    STORE  = 3'd3,
    ABORT  = 3'd4,
    GAP    = 3'd5
  } state_t;

  // Keeps only the bits actually shifted in for a transfer of the given length.
  function automatic logic [DATA_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [DATA_W-1:0] m;
    m = '1;
    case (len)
      LEN_8:   m = 32'h0000_00FF;
      LEN_16:  m = 32'h0000_FFFF;
      LEN_24:  m = 32'h00FF_FFFF;
      LEN_32:  m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count, registered not-full flag
// and first-word-fall-through head.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             do_push;
  logic             do_pop;

  // ready is low throughout reset, so nothing is accepted until the FIFO is clean
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      ready <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/spi_txn_scheduler.sv
// Queues host SPI commands and launches them one at a time on the spi_master
// start/busy handshake, collecting each received word into a response queue.
//
//   state  | meaning
//   IDLE   | waiting for a command, master idle and a free response slot
//   LAUNCH | start_trans asserted, waiting for busy to rise (or timeout)
//   RUN    | transfer in progress, waiting for busy to fall
//   STORE  | push masked rx word as response
//   ABORT  | push error response (master never went busy)
//   GAP    | enforced chip-select idle time before the next launch
module spi_txn_scheduler
  import spi_pkg::*;
#(
  parameter int CMD_DEPTH     = 4,
  parameter int RSP_DEPTH     = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int START_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [CHIP_W-1:0] cmd_chip,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CHIP_W-1:0] rsp_chip,
  output logic              rsp_err,
  output logic              start_trans,
  input  logic              busy,
  output logic [DATA_W-1:0] tx_data,
  input  logic [DATA_W-1:0] rx_data,
  output logic [LEN_W-1:0]  transaction_length,
  output logic [CHIP_W-1:0] chipADDRS,
  output logic              idle
);

  localparam int CMD_W = DATA_W + LEN_W + CHIP_W;
  localparam int RSP_W = DATA_W + CHIP_W + 1;
  localparam int TW    = $clog2(START_TIMEOUT + 2);
  localparam int GW    = $clog2(GAP_CYCLES + 2);
  localparam logic [TW-1:0] TO_LOAD  = TW'(START_TIMEOUT);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state;
  state_t            state_next;
  logic [CMD_W-1:0]  cmd_head;
  logic              cmd_empty;
  logic              cmd_pop;
  logic [RSP_W-1:0]  rsp_head;
  logic [RSP_W-1:0]  rsp_push_data;
  logic              rsp_push;
  logic              rsp_slot;
  logic              rsp_empty;
  logic [TW-1:0]     to_cnt;
  logic [GW-1:0]     gap_cnt;

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_valid),
    .push_data ({cmd_data, cmd_len, cmd_chip}),
    .ready     (cmd_ready),
    .pop       (cmd_pop),
    .head      (cmd_head),
    .empty     (cmd_empty)
  );

  // rsp_slot is the registered not-full flag, so a same-cycle host pop is credited next cycle
  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (rsp_push_data),
    .ready     (rsp_slot),
    .pop       (rsp_ready),
    .head      (rsp_head),
    .empty     (rsp_empty)
  );

  assign {rsp_data, rsp_chip, rsp_err} = rsp_head;
  assign rsp_valid = !rsp_empty;
  assign idle      = cmd_empty && (state == IDLE);

  always_comb begin
    state_next    = state;
    cmd_pop       = 1'b0;
    rsp_push      = 1'b0;
    rsp_push_data = '0;
    case (state)
      IDLE: begin
        if (!cmd_empty && !busy && rsp_slot) begin
          cmd_pop    = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (busy) begin
          state_next = RUN;
        end else if (to_cnt == '0) begin
          state_next = ABORT;
        end
      end
      RUN: begin
        if (!busy) state_next = STORE;
      end
      STORE: begin
        rsp_push      = 1'b1;
        rsp_push_data = {rx_data & len_mask(transaction_length), chipADDRS, 1'b0};
        state_next    = GAP;
      end
      ABORT: begin
        rsp_push      = 1'b1;
        rsp_push_data = {{DATA_W{1'b0}}, chipADDRS, 1'b1};
        state_next    = GAP;
      end
      GAP: begin
        if (gap_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state              <= IDLE;
      tx_data            <= '0;
      transaction_length <= '0;
      chipADDRS          <= '0;
      start_trans        <= 1'b0;
      to_cnt             <= '0;
      gap_cnt            <= '0;
    end else begin
      state <= state_next;
      if (cmd_pop) begin
        {tx_data, transaction_length, chipADDRS} <= cmd_head;
        to_cnt <= TO_LOAD;
      end else if (state == LAUNCH && to_cnt != '0) begin
        to_cnt <= to_cnt - 1'b1;
      end
      // one LAUNCH cycle per timeout count keeps start high for exactly START_TIMEOUT clocks
      start_trans <= (state == LAUNCH) && !busy && (to_cnt != '0);
      if (state_next == GAP && state != GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule
